// File: rtl/cm_sort_ser_pkg.sv
// Shared types and helpers for the sorted-vector serializer.
// Holds the FSM state enum and the duplicate-skip index search.
package cm_sort_ser_pkg;

  typedef enum logic {
    SER_IDLE,
    SER_EMIT
  } t_sort_ser_state;

  // Lowest j above idx whose neq bit is set; idx itself if none.
  function automatic int ser_next_idx(
    input logic [31:0] neq,
    input int          idx
  );
    int r;
    r = idx;
    for (int j = 31; j >= 0; j--) begin
      if (j > idx && neq[j]) r = j;
    end
    return r;
  endfunction

endpackage

// File: rtl/cm_sort_ser_if.sv
// Vector-in / element-out handshake bundle for cm_sort_ser.
// master drives the vector and consumer ready; slave is the serializer.
interface cm_sort_ser_if #(
  parameter int DCNT   = 4,
  parameter int DWIDTH = 8
);
  localparam int IW = (DCNT > 1) ? $clog2(DCNT) : 1;

  logic                   i_vld;
  logic                   o_rdy;
  logic [DCNT*DWIDTH-1:0] i_data;
  logic                   o_vld;
  logic                   i_rdy;
  logic [DWIDTH-1:0]      o_data;
  logic [IW-1:0]          o_idx;
  logic                   o_last;

  modport master (
    output i_vld, i_data, i_rdy,
    input  o_rdy, o_vld, o_data, o_idx, o_last
  );

  modport slave (
    input  i_vld, i_data, i_rdy,
    output o_rdy, o_vld, o_data, o_idx, o_last
  );
endinterface

// File: rtl/cm_sort_ser.sv
// Buffers one sorted vector and emits it one element per beat,
// lowest first, with optional skipping of repeated values.
module cm_sort_ser
  import cm_sort_ser_pkg::*;
#(
  parameter int DCNT   = 4,
  parameter int DWIDTH = 8,
  parameter bit DEDUP  = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  cm_sort_ser_if.slave  bus
);
  localparam int IW = (DCNT > 1) ? $clog2(DCNT) : 1;
  localparam int VW = DCNT * DWIDTH;

  t_sort_ser_state   state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     mem_q, mem_d;

  logic [DWIDTH-1:0] cur;
  logic [31:0]       neq;
  logic [IW-1:0]     nxt;
  logic              last;
  logic              in_xfer;
  logic              out_xfer;

  always_comb begin
    cur = mem_q[idx_q*DWIDTH +: DWIDTH];
    neq = '0;
    for (int j = 0; j < DCNT; j++) begin
      neq[j] = mem_q[j*DWIDTH +: DWIDTH] != cur;
    end
    // Sorted input: last element equal to current means no new value remains.
    if (DEDUP) begin
      nxt  = IW'(ser_next_idx(neq, int'(idx_q)));
      last = mem_q[(DCNT-1)*DWIDTH +: DWIDTH] == cur;
    end else begin
      nxt  = idx_q + IW'(1);
      last = idx_q == IW'(DCNT-1);
    end
  end

  assign bus.o_vld  = state_q == SER_EMIT;
  assign bus.o_data = cur;
  assign bus.o_idx  = idx_q;
  assign bus.o_last = bus.o_vld & last;
  assign out_xfer   = bus.o_vld & bus.i_rdy;
  assign bus.o_rdy  = (state_q == SER_IDLE) | (out_xfer & last);
  assign in_xfer    = bus.i_vld & bus.o_rdy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    unique case (state_q)
      SER_IDLE: begin
        if (in_xfer) begin
          mem_d   = bus.i_data;
          idx_d   = '0;
          state_d = SER_EMIT;
        end
      end
      SER_EMIT: begin
        if (out_xfer) begin
          if (!last) begin
            idx_d = nxt;
          end else if (in_xfer) begin
            mem_d = bus.i_data;
            idx_d = '0;
          end else begin
            idx_d   = '0;
            state_d = SER_IDLE;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SER_IDLE;
      idx_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
    end
  end

endmodule
